mxint_block_quantizer: RTL and testbench

Sequential, parametrised successor to the single-value MXINT8 broadcaster. It accepts a stream of float32 values, one per cycle, and collects a block of BLOCK_SIZE values. It derives the shared scale as the maximum biased exponent in the block, quantises every element to signed INT ELEM_WIDTH with round-to-nearest-even, and presents the packed MX block downstream with a valid/ready handshake. A broadcast mode reproduces the previous single-value behaviour: one float32 is replicated to all elements.

---
 rtl/mxint_block_quantizer.sv | 182 ++++++++++++++++++
 tb/tb_mxint_block_quantizer.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mxint_block_quantizer.sv
// ---------------------------------------------------------------------------
// mxint_block_quantizer
//
// Collects BLOCK_SIZE float32 values (one per accepted cycle), takes the
// largest biased exponent as the shared E8M0 scale and quantises every value
// to a signed ELEM_WIDTH integer with round-to-nearest-even.  The packed MX
// block is offered downstream with a valid/ready handshake.  A broadcast
// block takes a single float32 and replicates its quantised value into all
// slots.
//
// Ports:
//   i_clk             clock
//   i_rst             synchronous reset, active-high
//   i_valid/o_ready   input float32 handshake
//   i_float32         IEEE-754 single-precision input element
//   i_broadcast       sampled with element 0; 1 = single-value broadcast block
//   o_valid/i_ready   output block handshake
//   o_scale           shared E8M0 scale (0xFF when the block held NaN/Inf)
//   o_mxint_elements  element i at bits [i*ELEM_WIDTH +: ELEM_WIDTH]
//   o_busy            high whenever the FSM is not IDLE
// ---------------------------------------------------------------------------
module mxint_block_quantizer #(
    parameter int ELEM_WIDTH  = 8,
    parameter int BLOCK_SIZE  = 32,
    parameter int SCALE_WIDTH = 8
) (
    input  logic                             i_clk,
    input  logic                             i_rst,
    input  logic                             i_valid,
    output logic                             o_ready,
    input  logic [31:0]                      i_float32,
    input  logic                             i_broadcast,
    output logic                             o_valid,
    input  logic                             i_ready,
    output logic [SCALE_WIDTH-1:0]           o_scale,
    output logic [BLOCK_SIZE*ELEM_WIDTH-1:0] o_mxint_elements,
    output logic                             o_busy
);

    localparam int                IDX_W   = $clog2(BLOCK_SIZE);
    localparam logic [IDX_W-1:0]  LAST    = IDX_W'(BLOCK_SIZE - 1);
    localparam int                MAX_MAG = 2 ** (ELEM_WIDTH - 1) - 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        QUANT   = 2'd2,
        EMIT    = 2'd3
    } state_t;

    state_t                            r_state;
    logic [IDX_W-1:0]                  r_count;
    logic [IDX_W-1:0]                  r_qidx;
    logic [7:0]                        r_max_exp;
    logic                              r_nan;
    logic                              r_bcast;
    logic [SCALE_WIDTH-1:0]            r_scale;
    logic [BLOCK_SIZE*ELEM_WIDTH-1:0]  r_elems;
    logic [31:0]                       r_mem [BLOCK_SIZE];

    logic                              w_xfer;
    logic [7:0]                        w_exp;
    logic signed [ELEM_WIDTH-1:0]      w_q;

    // Shift a 24-bit magnitude right by s (s >= 1), rounding to nearest even
    // using the guard bit and the OR of everything below it.
    function automatic logic [24:0] round_shift(input logic [23:0] mag, input int s);
        logic [23:0] q;
        logic [23:0] mask;
        logic        g;
        logic        st;
        q    = mag >> s;
        g    = |(mag & (24'd1 << (s - 1)));
        mask = (24'd1 << (s - 1)) - 24'd1;
        st   = |(mag & mask);
        return {1'b0, q} + {24'd0, g & (st | q[0])};
    endfunction

    // Clamp a rounded magnitude to the symmetric signed range.
    function automatic logic [ELEM_WIDTH-1:0] saturate(input logic [24:0] r);
        if (r > 25'(MAX_MAG))
            return ELEM_WIDTH'(MAX_MAG);
        return r[ELEM_WIDTH-1:0];
    endfunction

    // Quantise one normal float32 against the shared scale.  Zero and
    // subnormal inputs flush to 0; shifts of 25 or more leave nothing.
    function automatic logic signed [ELEM_WIDTH-1:0] quantise(input logic [31:0] f,
                                                              input logic [7:0]  scale);
        logic [7:0]                   e;
        int                           s;
        logic signed [ELEM_WIDTH-1:0] m;
        e = f[30:23];
        s = 25 - ELEM_WIDTH + int'(scale) - int'(e);
        if (e == 8'd0 || s >= 25)
            return '0;
        m = signed'(saturate(round_shift({1'b1, f[22:0]}, s)));
        return f[31] ? -m : m;
    endfunction

    assign w_xfer = i_valid && o_ready;
    assign w_exp  = i_float32[30:23];
    // A NaN/Inf anywhere zeroes the whole block regardless of exponents.
    assign w_q    = r_nan ? '0 : quantise(r_mem[r_qidx], r_max_exp);

    assign o_ready          = (r_state == IDLE) || (r_state == COLLECT);
    assign o_valid          = (r_state == EMIT);
    assign o_busy           = (r_state != IDLE);
    assign o_scale          = r_scale;
    assign o_mxint_elements = r_elems;

    // Element storage is pure data and needs no reset: every slot that is
    // read in QUANT was written during the same block.
    always_ff @(posedge i_clk) begin
        if (w_xfer)
            r_mem[(r_state == IDLE) ? '0 : r_count] <= i_float32;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= IDLE;
            r_count   <= '0;
            r_qidx    <= '0;
            r_max_exp <= '0;
            r_nan     <= 1'b0;
            r_bcast   <= 1'b0;
            r_scale   <= '0;
            r_elems   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_xfer) begin
                        r_max_exp <= w_exp;
                        r_nan     <= (w_exp == 8'hFF);
                        r_bcast   <= i_broadcast;
                        r_qidx    <= '0;
                        if (i_broadcast) begin
                            r_state <= QUANT;
                        end else begin
                            r_state <= COLLECT;
                            r_count <= IDX_W'(1);
                        end
                    end
                end
                COLLECT: begin
                    if (w_xfer) begin
                        if (w_exp > r_max_exp)
                            r_max_exp <= w_exp;
                        if (w_exp == 8'hFF)
                            r_nan <= 1'b1;
                        if (r_count == LAST) begin
                            r_state <= QUANT;
                            r_count <= '0;
                        end else begin
                            r_count <= r_count + IDX_W'(1);
                        end
                    end
                end
                QUANT: begin
                    // A broadcast block writes its single result everywhere.
                    for (int i = 0; i < BLOCK_SIZE; i++) begin
                        if (r_bcast || int'(r_qidx) == i)
                            r_elems[i*ELEM_WIDTH +: ELEM_WIDTH] <= w_q;
                    end
                    if (r_bcast || r_qidx == LAST) begin
                        r_state <= EMIT;
                        r_qidx  <= '0;
                        r_scale <= r_nan ? SCALE_WIDTH'(8'hFF) : SCALE_WIDTH'(r_max_exp);
                    end else begin
                        r_qidx <= r_qidx + IDX_W'(1);
                    end
                end
                EMIT: begin
                    if (i_ready)
                        r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mxint_block_quantizer.sv
// ---------------------------------------------------------------------------
// Testbench for mxint_block_quantizer (ELEM_WIDTH=8, BLOCK_SIZE=32).
// Expected blocks come from a real-arithmetic reference model, are queued
// when a block is driven and popped when the DUT raises o_valid.
// ---------------------------------------------------------------------------
module tb_mxint_block_quantizer;

    localparam int EW = 8;
    localparam int BS = 32;
    localparam int W  = BS * EW;

    logic          i_clk = 1'b0;
    logic          i_rst;
    logic          i_valid;
    logic          o_ready;
    logic [31:0]   i_float32;
    logic          i_broadcast;
    logic          o_valid;
    logic          i_ready;
    logic [7:0]    o_scale;
    logic [W-1:0]  o_mxint_elements;
    logic          o_busy;

    mxint_block_quantizer #(
        .ELEM_WIDTH (EW),
        .BLOCK_SIZE (BS),
        .SCALE_WIDTH(8)
    ) dut (
        .i_clk           (i_clk),
        .i_rst           (i_rst),
        .i_valid         (i_valid),
        .o_ready         (o_ready),
        .i_float32       (i_float32),
        .i_broadcast     (i_broadcast),
        .o_valid         (o_valid),
        .i_ready         (i_ready),
        .o_scale         (o_scale),
        .o_mxint_elements(o_mxint_elements),
        .o_busy          (o_busy)
    );

    always #5 i_clk = ~i_clk;

    typedef struct packed {
        logic [7:0]   scale;
        logic [W-1:0] elems;
        int           lat;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] blk [BS];
    int          n_checks = 0;
    int          n_pass   = 0;

    task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Reference: value = 1.m * 2^(e-scale) * 2^(EW-2), rounded half-to-even.
    function automatic logic [EW-1:0] model_elem(input logic [31:0] f, input int scale);
        int  e;
        int  r;
        real x;
        real fl;
        e = int'(f[30:23]);
        if (e == 0)
            return '0;
        x  = real'({1'b1, f[22:0]}) / (2.0 ** 23) * (2.0 ** (e - scale)) * (2.0 ** (EW - 2));
        fl = $floor(x);
        r  = int'(fl);
        if ((x - fl) > 0.5 || ((x - fl) == 0.5 && (r % 2) == 1))
            r++;
        if (r > 2 ** (EW - 1) - 1)
            r = 2 ** (EW - 1) - 1;
        if (f[31])
            r = -r;
        return r[EW-1:0];
    endfunction

    function automatic exp_t model_block(input bit bcast);
        exp_t x;
        int   mx;
        bit   nan;
        int   n;
        mx  = 0;
        nan = 0;
        n   = bcast ? 1 : BS;
        for (int i = 0; i < n; i++) begin
            if (int'(blk[i][30:23]) > mx) mx = int'(blk[i][30:23]);
            if (blk[i][30:23] == 8'hFF) nan = 1;
        end
        x.scale = nan ? 8'hFF : mx[7:0];
        x.elems = '0;
        // o_valid lands BLOCK_SIZE+1 cycles after the last transfer cycle
        // (2 for broadcast): that is BS (or 1) further clock edges.
        x.lat   = bcast ? 1 : BS;
        for (int i = 0; i < BS; i++)
            x.elems[i*EW +: EW] = nan ? '0 : model_elem(bcast ? blk[0] : blk[i], mx);
        return x;
    endfunction

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic send(input logic [31:0] f, input logic b);
        int   w;
        logic rdy;
        w = 0;
        i_valid     = 1'b1;
        i_float32   = f;
        i_broadcast = b;
        do begin
            rdy = o_ready;
            tick();
            w++;
        end while (!rdy && w < 100);
        if (!rdy)
            check_eq("send_timeout", 0, 1);
        i_valid = 1'b0;
    endtask

    task automatic run_block(input bit bcast, input int hold);
        exp_t e;
        exp_t x;
        int   lat;
        sb.push_back(model_block(bcast));
        for (int i = 0; i < (bcast ? 1 : BS); i++)
            send(blk[i], (i == 0) ? bcast : 1'($urandom_range(0, 1)));
        lat = 0;
        while (!o_valid && lat < 200) begin
            tick();
            lat++;
        end
        if (!o_valid) begin
            check_eq("valid_timeout", 0, 1);
            return;
        end
        e = sb.pop_front();
        check_eq("latency", lat, e.lat);
        check_eq("scale", o_scale, e.scale);
        check_eq("elements", o_mxint_elements, e.elems);
        if (hold > 0) begin
            i_valid   = 1'b1;
            i_float32 = 32'h40000000;
            for (int k = 0; k < hold; k++) begin
                check_eq("bp_ready_low", o_ready, 0);
                tick();
                check_eq("bp_valid_held", o_valid, 1);
                check_eq("bp_scale_stable", o_scale, e.scale);
                check_eq("bp_elems_stable", o_mxint_elements, e.elems);
            end
            i_valid = 1'b0;
        end
        i_ready = 1'b1;
        check_eq("ready_not_same_cycle", o_ready, 0);
        tick();
        i_ready = 1'b0;
        check_eq("ready_after_handshake", o_ready, 1);
        check_eq("valid_after_handshake", o_valid, 0);
        x = e;
    endtask

    task automatic fill(input logic [31:0] v);
        for (int i = 0; i < BS; i++) blk[i] = v;
    endtask

    initial begin
        i_rst       = 1'b1;
        i_valid     = 1'b0;
        i_float32   = '0;
        i_broadcast = 1'b0;
        i_ready     = 1'b0;
        tick();
        tick();
        i_rst = 1'b0;
        check_eq("rst_busy", o_busy, 0);
        check_eq("rst_ready", o_ready, 1);
        check_eq("rst_valid", o_valid, 0);
        check_eq("rst_scale", o_scale, 0);
        check_eq("rst_elems", o_mxint_elements, 0);

        // All 1.0, then broadcast 1.0
        fill(32'h3F800000);
        run_block(0, 0);
        run_block(1, 0);

        // Mixed values
        fill(32'h0);
        blk[0] = 32'h3F800000;
        blk[1] = 32'h3E800000;
        blk[2] = 32'hBFC00000;
        run_block(0, 0);

        // Rounding, saturation, negative zero and subnormal
        fill(32'h0);
        blk[0] = 32'h3F800000;
        blk[1] = 32'h3FFFFFFF;
        blk[2] = 32'h3C000000;
        blk[3] = 32'h3C400000;
        blk[4] = 32'h3CC00000;
        blk[5] = 32'h80000000;
        blk[6] = 32'h00000001;
        blk[7] = 32'hBC400000;
        run_block(0, 0);

        // NaN in the middle of a block
        fill(32'h3F800000);
        blk[17] = 32'h7FC00000;
        run_block(0, 0);

        // All zero / subnormal
        fill(32'h0);
        blk[3] = 32'h00400000;
        run_block(0, 0);

        // Random normal values, with backpressure
        for (int i = 0; i < BS; i++)
            blk[i] = {1'($urandom_range(0, 1)), 8'($urandom_range(110, 140)), 23'($urandom)};
        run_block(0, 5);

        // Broadcast of a random negative value
        blk[0] = {1'b1, 8'd126, 23'($urandom)};
        run_block(1, 0);

        // Reset after 10 elements of a block
        for (int i = 0; i < 10; i++)
            send(32'h40400000, 1'b0);
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        check_eq("midrst_busy", o_busy, 0);
        check_eq("midrst_ready", o_ready, 1);
        check_eq("midrst_valid", o_valid, 0);
        check_eq("midrst_scale", o_scale, 0);
        check_eq("midrst_elems", o_mxint_elements, 0);
        fill(32'h0);
        blk[0]  = 32'h3F800000;
        blk[1]  = 32'h3E800000;
        blk[2]  = 32'hBFC00000;
        blk[31] = 32'h3F000000;
        run_block(0, 0);

        check_eq("scoreboard_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
